// File: rtl/deserializador_pkg.sv
// Shared definitions for the parametric serial-to-parallel deserializer:
// FSM state encoding, parameter defaults and a saturating counter helper.
package deserializador_pkg;

   // Link FSM state; plain constants keep the encoding visible to legacy tools
   typedef logic [1:0] state_t;
   localparam state_t HUNT   = 2'd0;
   localparam state_t ALIGN  = 2'd1;
   localparam state_t ACTIVE = 2'd2;

   // Parameter defaults for the deserializer top
   localparam int         DEF_WIDTH      = 8;
   localparam logic [7:0] DEF_COMMA      = 8'hBC;
   localparam int         DEF_LOCK_COUNT = 4;
   localparam int         DEF_LOSS_COUNT = 3;

   // Lock and miss counters only need to reach 15
   localparam int CNT_W = 4;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/deserializador_param_comparador_coma.sv
// Comma detector: flags when the candidate word equals the alignment symbol.
module comparador_coma
   import deserializador_pkg::*;
#(
   parameter int               WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] COMMA = WIDTH'(DEF_COMMA)
) (
   input  logic [WIDTH-1:0] i_word,
   output logic             o_match
);

   assign o_match = (i_word == COMMA);

endmodule

// File: rtl/deserializador_param.sv
// Serial-to-parallel deserializer with comma-based word alignment.
// Hunts for the comma on every bit, confirms it on LOCK_COUNT word
// boundaries, then delivers non-comma words and drops lock after
// LOSS_COUNT commas seen off the word boundary.
module deserializador_param
   import deserializador_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
   parameter int               LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int               LOSS_COUNT = DEF_LOSS_COUNT
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             active,
   output logic             word_strobe,
   output logic             sync_err
);

   localparam int               BC_W     = $clog2(WIDTH);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] LOSS_TGT = CNT_W'(LOSS_COUNT);

   // Registered state
   logic [WIDTH-2:0] r_sr;
   state_t           r_state;
   logic [BC_W-1:0]  r_bit_cnt;
   logic [CNT_W-1:0] r_lock_cnt;
   logic [CNT_W-1:0] r_miss_cnt;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_active;
   logic             r_strobe;
   logic             r_err;

   // Combinational next-state values
   logic [WIDTH-1:0] w_cw;
   logic             w_is_comma;
   logic             w_boundary;
   state_t           w_state_nxt;
   logic [BC_W-1:0]  w_bit_cnt_nxt;
   logic [CNT_W-1:0] w_lock_nxt;
   logic [CNT_W-1:0] w_miss_nxt;
   logic [CNT_W-1:0] w_lock_inc;
   logic [CNT_W-1:0] w_miss_inc;
   logic             w_valid_nxt;
   logic             w_strobe_nxt;
   logic             w_err_nxt;
   logic             w_load;

   // Candidate word: the last WIDTH-1 stored bits plus the bit on the wire now
   assign w_cw       = {r_sr, data_in};
   assign w_boundary = (r_bit_cnt == LAST_BIT);

   comparador_coma #(
      .WIDTH (WIDTH),
      .COMMA (COMMA)
   ) u_comparador_coma (
      .i_word  (w_cw),
      .o_match (w_is_comma)
   );

   // Alignment FSM and counter next-state decode
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_lock_nxt    = r_lock_cnt;
      w_miss_nxt    = r_miss_cnt;
      w_lock_inc    = sat_inc(r_lock_cnt);
      w_miss_inc    = sat_inc(r_miss_cnt);
      w_valid_nxt   = 1'b0;
      w_strobe_nxt  = 1'b0;
      w_err_nxt     = 1'b0;
      w_load        = 1'b0;

      if (r_state != HUNT) begin
         w_bit_cnt_nxt = w_boundary ? '0 : r_bit_cnt + 1'b1;
      end

      case (r_state)
         HUNT: begin
            if (w_is_comma) begin
               // The comma just ended a word: next sampled bit is bit 0
               w_bit_cnt_nxt = '0;
               w_lock_nxt    = CNT_W'(1);
               if (LOCK_COUNT <= 1) begin
                  w_state_nxt = ACTIVE;
                  w_miss_nxt  = '0;
               end else begin
                  w_state_nxt = ALIGN;
               end
            end
         end
         ALIGN: begin
            if (w_boundary) begin
               w_strobe_nxt = 1'b1;
               if (w_is_comma) begin
                  w_lock_nxt = w_lock_inc;
                  if (w_lock_inc >= LOCK_TGT) begin
                     w_state_nxt = ACTIVE;
                     w_miss_nxt  = '0;
                  end
               end else begin
                  w_state_nxt   = HUNT;
                  w_lock_nxt    = '0;
                  w_bit_cnt_nxt = '0;
               end
            end
         end
         ACTIVE: begin
            if (w_boundary) begin
               w_strobe_nxt = 1'b1;
               if (w_is_comma) begin
                  w_miss_nxt = '0;
               end else begin
                  w_valid_nxt = 1'b1;
                  w_load      = 1'b1;
               end
            end else if (w_is_comma) begin
               // Comma straddling a word boundary: alignment is suspect
               w_err_nxt  = 1'b1;
               w_miss_nxt = w_miss_inc;
               if (w_miss_inc >= LOSS_TGT) begin
                  w_state_nxt   = HUNT;
                  w_lock_nxt    = '0;
                  w_bit_cnt_nxt = '0;
               end
            end
         end
         default: begin
            w_state_nxt   = HUNT;
            w_lock_nxt    = '0;
            w_miss_nxt    = '0;
            w_bit_cnt_nxt = '0;
         end
      endcase
   end

   // State, counters and output registers with asynchronous clear
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         r_sr       <= '0;
         r_state    <= HUNT;
         r_bit_cnt  <= '0;
         r_lock_cnt <= '0;
         r_miss_cnt <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_active   <= 1'b0;
         r_strobe   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
         r_sr       <= w_cw[WIDTH-2:0];
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_lock_cnt <= w_lock_nxt;
         r_miss_cnt <= w_miss_nxt;
         r_valid    <= w_valid_nxt;
         r_active   <= (w_state_nxt == ACTIVE);
         r_strobe   <= w_strobe_nxt;
         r_err      <= w_err_nxt;
         if (w_load) begin
            r_data <= w_cw;
         end
      end
   end

   assign data_out    = r_data;
   assign valid_out   = r_valid;
   assign active      = r_active;
   assign word_strobe = r_strobe;
   assign sync_err    = r_err;

endmodule

// File: tb/tb_deserializador_param.sv
// Self-checking bench for deserializador_param (WIDTH=8, COMMA=BC,
// LOCK_COUNT=4, LOSS_COUNT=3): word-level table, directed corner
// sequences and a random stream, all against a per-bit reference model.
module tb_deserializador_param;

   localparam int         W      = 8;
   localparam logic [7:0] K      = 8'hBC;
   localparam int         LOCK_N = 4;
   localparam int         LOSS_N = 3;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b1;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic       word_strobe;
   logic       sync_err;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;
   int cnt_strobe = 0;
   int cnt_err = 0;
   int cnt_valid = 0;

   deserializador_param #(
      .WIDTH      (W),
      .COMMA      (K),
      .LOCK_COUNT (LOCK_N),
      .LOSS_COUNT (LOSS_N)
   ) dut (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .data_in     (data_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .active      (active),
      .word_strobe (word_strobe),
      .sync_err    (sync_err)
   );

   always #5 clk_32f = ~clk_32f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Word phase is derived arithmetically from the edge index of the comma
   // that started alignment, not from a bit counter.
   typedef enum {SEEK, LOCKING, LOCKED} mode_t;
   mode_t      m_mode   = SEEK;
   logic [7:0] m_hist   = '0;
   logic [7:0] m_data   = '0;
   int         m_cyc    = 0;
   int         m_anchor = 0;
   int         m_locks  = 0;
   int         m_misses = 0;
   logic       m_valid  = 1'b0;
   logic       m_strobe = 1'b0;
   logic       m_err    = 1'b0;

   task automatic model_reset();
      m_mode = SEEK; m_hist = '0; m_data = '0; m_cyc = 0; m_anchor = 0;
      m_locks = 0; m_misses = 0; m_valid = 1'b0; m_strobe = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic b);
      logic comma;
      logic boundary;
      m_cyc++;
      m_hist   = {m_hist[6:0], b};
      comma    = (m_hist == K);
      boundary = (m_mode != SEEK) && (((m_cyc - m_anchor) % W) == 0);
      m_valid  = 1'b0;
      m_strobe = 1'b0;
      m_err    = 1'b0;
      case (m_mode)
         SEEK: if (comma) begin
            m_anchor = m_cyc;
            m_locks  = 1;
            m_misses = 0;
            m_mode   = (LOCK_N == 1) ? LOCKED : LOCKING;
         end
         LOCKING: if (boundary) begin
            m_strobe = 1'b1;
            if (comma) begin
               m_locks++;
               if (m_locks >= LOCK_N) begin
                  m_mode = LOCKED; m_misses = 0;
               end
            end else begin
               m_mode = SEEK; m_locks = 0;
            end
         end
         LOCKED: if (boundary) begin
            m_strobe = 1'b1;
            if (comma) m_misses = 0;
            else begin
               m_data = m_hist; m_valid = 1'b1;
            end
         end else if (comma) begin
            m_err = 1'b1;
            m_misses++;
            if (m_misses >= LOSS_N) m_mode = SEEK;
         end
         default: m_mode = SEEK;
      endcase
   endtask

   // Per-cycle comparison of every output against the model, 1 unit after each edge
   initial begin : chk_proc
      logic b;
      logic r;
      forever begin
         @(posedge clk_32f);
         b = data_in;
         r = reset;
         if (r) model_reset();
         else   model_step(b);
         #1;
         if (chk_en) begin
            check("cycle{act,vld,stb,err,data}",
                  {20'd0, active, valid_out, word_strobe, sync_err, data_out},
                  {20'd0, (m_mode == LOCKED), m_valid, m_strobe, m_err, m_data});
            cnt_strobe += int'(word_strobe);
            cnt_err    += int'(sync_err);
            cnt_valid  += int'(valid_out);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_bit(input logic b);
      @(negedge clk_32f);
      data_in = b;
      @(posedge clk_32f);
      #2;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic do_reset();
      @(negedge clk_32f);
      reset   = 1'b1;
      data_in = 1'b0;
      repeat (2) @(negedge clk_32f);
      reset = 1'b0;
   endtask

   typedef struct {
      logic [7:0] word;
      logic       exp_active;
      logic       exp_valid;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl[10];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      int s0;
      int v0;
      int e0;
      int r;

      tbl[0] = '{8'hBC, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{8'hBC, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{8'hBC, 1'b0, 1'b0, 8'h00};
      tbl[3] = '{8'hBC, 1'b1, 1'b0, 8'h00};
      tbl[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A};
      tbl[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
      tbl[6] = '{8'hBC, 1'b1, 1'b0, 8'h3C};
      tbl[7] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
      tbl[8] = '{8'hBC, 1'b1, 1'b0, 8'hFF};
      tbl[9] = '{8'h00, 1'b1, 1'b1, 8'h00};

      // Reset state
      repeat (3) @(negedge clk_32f);
      chk_en = 1'b1;
      check("reset_state", {active, valid_out, word_strobe, sync_err, data_out}, 32'd0);
      reset = 1'b0;

      // Lock on four commas, then data words with interleaved aligned commas
      s0 = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 6) s0 = cnt_strobe;
         send_word(tbl[i].word);
         check($sformatf("tbl[%0d].active", i), active,    tbl[i].exp_active);
         check($sformatf("tbl[%0d].valid", i),  valid_out, tbl[i].exp_valid);
         check($sformatf("tbl[%0d].data", i),   data_out,  tbl[i].exp_data);
      end
      check("strobes_over_4_words", cnt_strobe - s0, 4);

      // Broken alignment: BC,BC,11 falls back to hunt, needs four fresh commas
      do_reset();
      v0 = cnt_valid;
      send_word(K);
      send_word(K);
      send_word(8'h11);
      check("after_11.active", active, 1'b0);
      check("no_valid_for_11", cnt_valid - v0, 0);
      repeat (3) send_word(K);
      check("relock_3_of_4.active", active, 1'b0);
      send_word(K);
      check("relock_4_of_4.active", active, 1'b1);

      // Three misaligned commas drop lock; last one suppresses its word
      send_word(8'h22);
      e0 = cnt_err;
      for (int p = 0; p < 3; p++) begin
         v0 = cnt_valid;
         repeat (4) send_bit(1'b0);
         send_word(K);
         repeat (4) send_bit(1'b0);
         if (p < 2) check($sformatf("misalign_%0d.active", p), active, 1'b1);
      end
      check("misalign.sync_err_count", cnt_err - e0, 3);
      check("misalign.active_dropped", active, 1'b0);
      check("misalign.valid_in_last_pattern", cnt_valid - v0, 1);

      // Random bits (no comma possible: never four 1s in a row), then comma at offset 3
      do_reset();
      for (int i = 0; i < 18; i++) send_bit((i % 4 == 3) ? 1'b0 : 1'($urandom_range(0, 1)));
      repeat (4) send_word(K);
      check("offset_lock.active", active, 1'b1);
      send_word(8'h96);
      check("offset_lock.valid", valid_out, 1'b1);
      check("offset_lock.data", data_out, 8'h96);

      // Reset mid-word while active clears everything at once
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      #1;
      reset = 1'b1;
      #1;
      check("async_reset.outputs", {active, valid_out, word_strobe, sync_err, data_out}, 32'd0);
      repeat (2) @(negedge clk_32f);
      reset = 1'b0;
      repeat (3) send_word(K);
      check("post_reset_3_of_4.active", active, 1'b0);
      send_word(K);
      check("post_reset_4_of_4.active", active, 1'b1);

      // Random stream of commas, data, slips and misaligned commas
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4)       send_word(K);
         else if (r < 8)  send_word(8'($urandom));
         else if (r == 8) repeat ($urandom_range(1, 7)) send_bit(1'($urandom));
         else begin
            repeat (3) send_bit(1'b0);
            send_word(K);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
